// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle, ALU op encodings and datapath widths.
package pipe_pkg;

    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write_en;
        logic    mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, default: 1'b0};

    // Saturating increment for 32-bit event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational ID-stage logic: operand select with x0 forcing and WB bypass,
// load-use detection and the stall request toward IF/ID.
module id_hazard_unit
    import pipe_pkg::*;
#(
    parameter int XLEN   = PIPE_XLEN,
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [XLEN-1:0]   read_data1,
    input  logic [XLEN-1:0]   read_data2,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              flush,
    input  logic              ex_hold,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic              load_use,
    output logic              stall
);

    // The register file writes on the edge, so a same-cycle read is stale and WB must bypass it.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_data,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_idx,
        input logic [XLEN-1:0]   wb_val
    );
        if (rs == {REG_AW{1'b0}}) begin
            return {XLEN{1'b0}};
        end else if (wb_we && (wb_idx == rs)) begin
            return wb_val;
        end else begin
            return rf_data;
        end
    endfunction

    logic hit_s;

    // Operand select and hazard detection.
    always_comb begin
        op1      = sel_operand(rs1, read_data1, wb_reg_write, wb_rd, wb_data);
        op2      = sel_operand(rs2, read_data2, wb_reg_write, wb_rd, wb_data);
        hit_s    = (ex_rd == rs1) || (ex_rd == rs2);
        load_use = in_valid && ex_valid && ex_mem_read &&
                   (ex_rd != {REG_AW{1'b0}}) && hit_s;
        stall    = (load_use || ex_hold) && !flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/bubble priority.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = PIPE_XLEN,
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    input  logic [XLEN-1:0]   InPC,
    input  logic [REG_AW-1:0] Rs1,
    input  logic [REG_AW-1:0] Rs2,
    input  logic [REG_AW-1:0] Rd,
    input  logic [XLEN-1:0]   Imm,
    input  ctrl_t             InCtrl,
    input  logic [XLEN-1:0]   ReadData1,
    input  logic [XLEN-1:0]   ReadData2,
    output logic              RegRead,
    input  logic              WbRegWrite,
    input  logic [REG_AW-1:0] WbRd,
    input  logic [XLEN-1:0]   WbData,
    input  logic              Flush,
    input  logic              ExHold,
    output logic              Stall,
    output logic              ExValid,
    output logic [XLEN-1:0]   ExPC,
    output logic [XLEN-1:0]   ExImm,
    output logic [XLEN-1:0]   ExOp1,
    output logic [XLEN-1:0]   ExOp2,
    output logic [REG_AW-1:0] ExRs1,
    output logic [REG_AW-1:0] ExRs2,
    output logic [REG_AW-1:0] ExRd,
    output ctrl_t             ExCtrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
`endif
);

    logic [XLEN-1:0]   op1_s;
    logic [XLEN-1:0]   op2_s;
    logic              load_use_s;
    logic              ex_valid_r;
    logic [XLEN-1:0]   ex_pc_r;
    logic [XLEN-1:0]   ex_imm_r;
    logic [XLEN-1:0]   ex_op1_r;
    logic [XLEN-1:0]   ex_op2_r;
    logic [REG_AW-1:0] ex_rs1_r;
    logic [REG_AW-1:0] ex_rs2_r;
    logic [REG_AW-1:0] ex_rd_r;
    ctrl_t             ex_ctrl_r;

    id_hazard_unit #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_hazard (
        .in_valid     (InValid),
        .rs1          (Rs1),
        .rs2          (Rs2),
        .read_data1   (ReadData1),
        .read_data2   (ReadData2),
        .wb_reg_write (WbRegWrite),
        .wb_rd        (WbRd),
        .wb_data      (WbData),
        .ex_valid     (ex_valid_r),
        .ex_mem_read  (ex_ctrl_r.mem_read),
        .ex_rd        (ex_rd_r),
        .flush        (Flush),
        .ex_hold      (ExHold),
        .op1          (op1_s),
        .op2          (op2_s),
        .load_use     (load_use_s),
        .stall        (Stall)
    );

    // ID/EX register: flush beats hold, hold beats bubble, otherwise load.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_valid_r <= 1'b0;
            ex_pc_r    <= {XLEN{1'b0}};
            ex_imm_r   <= {XLEN{1'b0}};
            ex_op1_r   <= {XLEN{1'b0}};
            ex_op2_r   <= {XLEN{1'b0}};
            ex_rs1_r   <= {REG_AW{1'b0}};
            ex_rs2_r   <= {REG_AW{1'b0}};
            ex_rd_r    <= {REG_AW{1'b0}};
            ex_ctrl_r  <= CTRL_NOP;
        end else if (Flush) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= CTRL_NOP;
        end else if (ExHold) begin
            ex_valid_r <= ex_valid_r;
        end else if (load_use_s) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= CTRL_NOP;
        end else begin
            ex_valid_r <= InValid;
            ex_pc_r    <= InPC;
            ex_imm_r   <= Imm;
            ex_op1_r   <= op1_s;
            ex_op2_r   <= op2_s;
            ex_rs1_r   <= Rs1;
            ex_rs2_r   <= Rs2;
            ex_rd_r    <= Rd;
            // An invalid entry must never carry live control bits into EX.
            ex_ctrl_r  <= InValid ? InCtrl : CTRL_NOP;
        end
    end

    assign RegRead = InValid;
    assign ExValid = ex_valid_r;
    assign ExPC    = ex_pc_r;
    assign ExImm   = ex_imm_r;
    assign ExOp1   = ex_op1_r;
    assign ExOp2   = ex_op2_r;
    assign ExRs1   = ex_rs1_r;
    assign ExRs2   = ex_rs2_r;
    assign ExRd    = ex_rd_r;
    assign ExCtrl  = ex_ctrl_r;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating event counters; holds are not counted as load-use stalls.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (load_use_s && !Flush && !ExHold) begin
                stall_cnt_r <= sat_inc32(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (Flush) begin
                flush_cnt_r <= sat_inc32(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign StallCount = stall_cnt_r;
    assign FlushCount = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven self-checking bench for id_ex_stage (optionally with ID_EX_PERF_CNT_EN).
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic [31:0] InPC;
    logic [4:0]  Rs1, Rs2, Rd;
    logic [31:0] Imm;
    ctrl_t       InCtrl;
    logic [31:0] ReadData1, ReadData2;
    logic        RegRead;
    logic        WbRegWrite;
    logic [4:0]  WbRd;
    logic [31:0] WbData;
    logic        Flush, ExHold;
    logic        Stall;
    logic        ExValid;
    logic [31:0] ExPC, ExImm, ExOp1, ExOp2;
    logic [4:0]  ExRs1, ExRs2, ExRd;
    ctrl_t       ExCtrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] StallCount, FlushCount;
`endif

    id_ex_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InPC(InPC),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Imm(Imm), .InCtrl(InCtrl),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .RegRead(RegRead),
        .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbData(WbData),
        .Flush(Flush), .ExHold(ExHold), .Stall(Stall), .ExValid(ExValid),
        .ExPC(ExPC), .ExImm(ExImm), .ExOp1(ExOp1), .ExOp2(ExOp2),
        .ExRs1(ExRs1), .ExRs2(ExRs2), .ExRd(ExRd), .ExCtrl(ExCtrl)
`ifdef ID_EX_PERF_CNT_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        ctrl_t       ctrl;
        logic [31:0] rd1, rd2;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        fl, hold;
        logic        e_stall, e_valid;
        ctrl_t       e_ctrl;
        logic [31:0] e_op1, e_op2;
        logic        chk;
    } vec_t;

    localparam ctrl_t C_ALU = '{alu_op: ALU_SUB, alu_src: 1'b0, mem_read: 1'b0,
                                mem_write: 1'b0, reg_write_en: 1'b1, mem_to_reg: 1'b0};
    localparam ctrl_t C_LD  = '{alu_op: ALU_ADD, alu_src: 1'b1, mem_read: 1'b1,
                                mem_write: 1'b0, reg_write_en: 1'b1, mem_to_reg: 1'b1};
    localparam ctrl_t C_ST  = '{alu_op: ALU_ADD, alu_src: 1'b1, mem_read: 1'b0,
                                mem_write: 1'b1, reg_write_en: 1'b0, mem_to_reg: 1'b0};

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[14];

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic [31:0] imm, input ctrl_t ctrl,
        input logic [31:0] rd1, input logic [31:0] rd2, input logic wb_we,
        input logic [4:0] wb_rd, input logic [31:0] wb_data, input logic fl, input logic hold,
        input logic e_stall, input logic e_valid, input ctrl_t e_ctrl,
        input logic [31:0] e_op1, input logic [31:0] e_op2, input logic chk);
        vec_t r;
        r.v = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm; r.ctrl = ctrl;
        r.rd1 = rd1; r.rd2 = rd2; r.wb_we = wb_we; r.wb_rd = wb_rd; r.wb_data = wb_data;
        r.fl = fl; r.hold = hold; r.e_stall = e_stall; r.e_valid = e_valid; r.e_ctrl = e_ctrl;
        r.e_op1 = e_op1; r.e_op2 = e_op2; r.chk = chk;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        InValid = v.v; InPC = v.pc; Rs1 = v.rs1; Rs2 = v.rs2; Rd = v.rd; Imm = v.imm;
        InCtrl = v.ctrl; ReadData1 = v.rd1; ReadData2 = v.rd2; WbRegWrite = v.wb_we;
        WbRd = v.wb_rd; WbData = v.wb_data; Flush = v.fl; ExHold = v.hold;
    endtask

    // Called #1 after a rising edge: drive, check Stall, clock, check registered outputs.
    task automatic apply(input vec_t v, input string tag);
        drive(v);
        #1;
        chk({tag, ".stall"}, 64'(Stall), 64'(v.e_stall));
        chk({tag, ".regread"}, 64'(RegRead), 64'(v.v));
        @(posedge Clk);
        #1;
        chk({tag, ".valid"}, 64'(ExValid), 64'(v.e_valid));
        chk({tag, ".ctrl"}, 64'(ExCtrl), 64'(v.e_ctrl));
        if (v.chk) begin
            chk({tag, ".pc"}, 64'(ExPC), 64'(v.pc));
            chk({tag, ".imm"}, 64'(ExImm), 64'(v.imm));
            chk({tag, ".rs1"}, 64'(ExRs1), 64'(v.rs1));
            chk({tag, ".rs2"}, 64'(ExRs2), 64'(v.rs2));
            chk({tag, ".rd"}, 64'(ExRd), 64'(v.rd));
            chk({tag, ".op1"}, 64'(ExOp1), 64'(v.e_op1));
            chk({tag, ".op2"}, 64'(ExOp2), 64'(v.e_op2));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 64'(ExValid), 64'd0);
        chk({tag, ".ctrl"}, 64'(ExCtrl), 64'd0);
        chk({tag, ".pc"}, 64'(ExPC), 64'd0);
        chk({tag, ".imm"}, 64'(ExImm), 64'd0);
        chk({tag, ".op1"}, 64'(ExOp1), 64'd0);
        chk({tag, ".op2"}, 64'(ExOp2), 64'd0);
        chk({tag, ".rd"}, 64'(ExRd), 64'd0);
        chk({tag, ".stall"}, 64'(Stall), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, ".stallcnt"}, 64'(StallCount), 64'd0);
        chk({tag, ".flushcnt"}, 64'(FlushCount), 64'd0);
`endif
    endtask

    initial begin
        vec_t hv;
        //             v    pc        rs1 rs2 rd  imm       ctrl   rd1        rd2       we   wbrd wbdata      fl   hold  stl  vld  e_ctrl    op1        op2        chk
        tbl[0]  = mk(1'b1, 32'h100, 5'd3, 5'd4, 5'd8, 32'h10, C_ALU, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, C_ALU, 32'h11, 32'h22, 1'b1);
        tbl[1]  = mk(1'b1, 32'h104, 5'd5, 5'd6, 5'd9, 32'h14, C_ALU, 32'hAAAA, 32'h66, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, C_ALU, 32'h1234, 32'h66, 1'b1);
        tbl[2]  = mk(1'b1, 32'h108, 5'd0, 5'd5, 5'd0, 32'h0, C_ST, 32'h5555, 32'h77, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, C_ST, 32'h0, 32'h77, 1'b1);
        tbl[3]  = mk(1'b1, 32'h10C, 5'd1, 5'd9, 5'd2, 32'h1C, C_ALU, 32'h1, 32'h99, 1'b1, 5'd9, 32'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, C_ALU, 32'h1, 32'hBEEF, 1'b1);
        tbl[4]  = mk(1'b1, 32'h110, 5'd2, 5'd0, 5'd7, 32'h20, C_LD, 32'h200, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, C_LD, 32'h200, 32'h0, 1'b1);
        tbl[5]  = mk(1'b1, 32'h114, 5'd1, 5'd7, 5'd10, 32'h24, C_ALU, 32'h1, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, CTRL_NOP, 32'h0, 32'h0, 1'b0);
        tbl[6]  = mk(1'b1, 32'h114, 5'd1, 5'd7, 5'd10, 32'h24, C_ALU, 32'h1, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, C_ALU, 32'h1, 32'h7, 1'b1);
        tbl[7]  = mk(1'b0, 32'h118, 5'd3, 5'd4, 5'd5, 32'h0, C_ALU, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_NOP, 32'h3, 32'h4, 1'b1);
        tbl[8]  = mk(1'b1, 32'h11C, 5'd0, 5'd0, 5'd7, 32'h0, C_LD, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, C_LD, 32'h0, 32'h0, 1'b1);
        tbl[9]  = mk(1'b1, 32'h120, 5'd7, 5'd0, 5'd11, 32'h0, C_ALU, 32'h70, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, CTRL_NOP, 32'h0, 32'h0, 1'b0);
        tbl[10] = mk(1'b1, 32'h124, 5'd7, 5'd3, 5'd12, 32'h8, C_ALU, 32'h70, 32'h30, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, C_ALU, 32'h70, 32'h30, 1'b1);
        tbl[11] = mk(1'b1, 32'h128, 5'd1, 5'd2, 5'd3, 32'h0, C_ALU, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, CTRL_NOP, 32'h0, 32'h0, 1'b0);
        tbl[12] = mk(1'b1, 32'h12C, 5'd0, 5'd0, 5'd0, 32'h0, C_LD, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, C_LD, 32'h0, 32'h0, 1'b1);
        tbl[13] = mk(1'b1, 32'h130, 5'd0, 5'd0, 5'd4, 32'h4, C_ALU, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, C_ALU, 32'h0, 32'h0, 1'b1);

        Rst_n = 1'b0;
        drive(mk(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, CTRL_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, CTRL_NOP, 32'h0, 32'h0, 1'b0));
        repeat (2) @(posedge Clk);
        #1;
        chk_reset("reset");
        Rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Load into EX, then hold it three cycles while ID inputs churn.
        apply(mk(1'b1, 32'h300, 5'd11, 5'd12, 5'd13, 32'h33, C_LD, 32'hA1, 32'hA2, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, C_LD, 32'hA1, 32'hA2, 1'b1), "hold_ld");
        for (int i = 0; i < 3; i++) begin
            hv = mk(1'b1, 32'h400 + 32'(i), 5'd13, 5'd1, 5'd14, 32'(i), C_ALU, 32'(i), 32'(i), 1'b0,
                    5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, C_LD, 32'h0, 32'h0, 1'b0);
            apply(hv, $sformatf("hold%0d", i));
            chk($sformatf("hold%0d.pc", i), 64'(ExPC), 64'h300);
            chk($sformatf("hold%0d.op1", i), 64'(ExOp1), 64'hA1);
            chk($sformatf("hold%0d.op2", i), 64'(ExOp2), 64'hA2);
            chk($sformatf("hold%0d.rd", i), 64'(ExRd), 64'd13);
            chk($sformatf("hold%0d.imm", i), 64'(ExImm), 64'h33);
`ifdef ID_EX_PERF_CNT_EN
            chk($sformatf("hold%0d.stallcnt", i), 64'(StallCount), 64'd1);
`endif
        end
        apply(mk(1'b1, 32'h500, 5'd13, 5'd1, 5'd14, 32'h50, C_ALU, 32'h13, 32'h1, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, CTRL_NOP, 32'h0, 32'h0, 1'b0), "lu_bubble");
        apply(mk(1'b1, 32'h500, 5'd13, 5'd1, 5'd14, 32'h50, C_ALU, 32'h13, 32'h1, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, C_ALU, 32'h13, 32'h1, 1'b1), "lu_issue");
`ifdef ID_EX_PERF_CNT_EN
        chk("perf.stallcnt", 64'(StallCount), 64'd2);
        chk("perf.flushcnt", 64'(FlushCount), 64'd2);
`endif

        // Asynchronous reset between edges, then the first edge after release loads normally.
        Rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        apply(tbl[0], "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly downstream of the register file. It takes the decoded instruction fields and the two register-file read ports and applies x0 forcing and a writeback bypass to the operands. It detects load-use hazards and registers everything into the ID/EX pipeline register consumed by the execute stage. It owns stall generation toward IF/ID and bubble insertion into EX.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports:
- Clk  in  1  pipeline clock
- Rst_n  in  1  asynchronous active-low reset
- InValid  in  1  IF/ID holds a valid instruction
- InPC  in  XLEN  instruction PC
- Rs1, Rs2, Rd  in  REG_AW  decoded register indices
- Imm  in  XLEN  decoded immediate
- InCtrl  in  ctrl_t  decoded control bundle (AluOp[3:0], AluSrc, MemRead, MemWrite, RegWriteEn, MemToReg)
- ReadData1, ReadData2  in  XLEN  register-file read data for Rs1/Rs2
- RegRead  out  1  read enable to register file, equals InValid
- WbRegWrite  in  1  writeback stage writes this cycle
- WbRd  in  REG_AW  writeback destination
- WbData  in  XLEN  writeback data
- Flush  in  1  branch/jump redirect from EX, kills instruction in ID
- ExHold  in  1  downstream busy, freeze ID/EX register
- Stall  out  1  combinational, IF/ID must hold its contents
- ExValid  out  1  ID/EX entry valid
- ExPC, ExImm, ExOp1, ExOp2  out  XLEN  registered PC, immediate, operands
- ExRs1, ExRs2, ExRd  out  REG_AW  registered indices, used by the EX forwarding unit
- ExCtrl  out  ctrl_t  registered control bundle

## Operation
- Operand select, per source n in {1,2}: Rsn==0 gives 0. Otherwise WbRegWrite && WbRd==Rsn gives WbData (bypass). Otherwise ReadDatan.
- Load-use hazard: InValid && ExValid && ExCtrl.MemRead && ExRd!=0 && (ExRd==Rs1 || ExRd==Rs2). Rs2 compares for all instructions; false stalls are accepted.
- Stall = (LoadUse || ExHold) && !Flush.
- Per-edge update, in priority order:
  - Flush: ExValid<=0, ExCtrl<=0.
  - ExHold: all Ex* hold.
  - LoadUse: bubble. ExValid<=0, ExCtrl<=0, data fields don't-care.
  - Otherwise: load all inputs, ExValid<=InValid.
- A bubble or invalid entry always carries ExCtrl all-zero, so no RegWriteEn/MemWrite leaks.
- Reset: ExValid=0, ExCtrl=0, all Ex* data/index outputs 0. Stall evaluates to 0 while reset holds ExValid=0.

## Timing
- Latency: 1 cycle, ID inputs at edge N appear on Ex* after edge N.
- Stall is combinational from current inputs and Ex* state. It has no registered delay.
- A load-use stall lasts exactly 1 cycle when ExHold=0. The bubble clears ExValid, which drops the hazard term.
- Flush and ExHold together: Flush wins, entry is killed, Stall=0.
- Flush and LoadUse together: Flush wins, no stall.
- Bypass and x0 forcing are combinational in the same cycle as the WB write. The register file writes on edge, so a same-cycle read would otherwise be stale.
- Reset deasserted mid-stream: the first edge after release loads normally.

## Configuration
- ID_EX_PERF_CNT_EN defined: adds outputs StallCount and FlushCount, both 32 bits.
  - StallCount increments on each cycle with LoadUse && !Flush && !ExHold.
  - FlushCount increments on each Flush cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - ctrl_t packed struct
  - ALU op encodings
  - XLEN/REG_AW constants
  - CTRL_NOP (all-zero) constant
- Sub-module id_hazard_unit holds the combinational part: operand select, load-use compare and Stall. The top level holds the ID/EX register and the optional counters.

## Test plan
- Reset: Rst_n=0 mid-run. All Ex* go to 0 immediately, with no clock needed, and Stall=0.
- Plain pass-through: InValid=1, Rs1=3, ReadData1=0x11, Rs2=4, ReadData2=0x22. Next cycle ExOp1=0x11, ExOp2=0x22, ExValid=1.
- Bypass: Rs1=5, ReadData1=0xAAAA, WbRegWrite=1, WbRd=5, WbData=0x1234 gives ExOp1=0x1234. With Rs1=0 and the same WB write to WbRd=0, ExOp1=0.
- Load-use: EX holds a MemRead with ExRd=7, and ID has Rs2=7. Stall=1 for 1 cycle, then ExValid=0 with ExCtrl=0. The cycle after, the instruction issues with ExValid=1.
- Flush priority: Flush=1 with ExHold=1 and a load-use hazard present. Stall=0, and next cycle ExValid=0.
- ExHold: hold 3 cycles while inputs change. Ex* stay constant and Stall=1 throughout. With ID_EX_PERF_CNT_EN defined, StallCount is unchanged by the holds and counts only load-use cycles.
